reg_write_arbiter: RTL
======================

// Module: reg_write_arbiter
// PURPOSE
//  Shares the register file's single write port (WE3/A3/WD3) between two writeback sources.
//  Port 0 is the in-order pipeline writeback: highest priority, no back-pressure.
//  Port 1 is a multi-cycle unit (divider / load return) using a valid/ready handshake.
//  Port 1 results that lose arbitration wait in a DEPTH-entry FIFO.
//  A read-address scoreboard flags decode hazards against writes still held in the FIFO.
// PARAMETERS
//  ADDRESS_WIDTH  5   register address width
//  DATA_WIDTH     32  register data width
//  DEPTH          4   port-1 holding FIFO entries (power of 2, >=2)
//  STARVE_MAX     8   consecutive lost cycles before pipeline is stalled to drain FIFO
// PORTS
//  CLK        in   1   clock
//  RST        in   1   synchronous active-high reset
//  p0_valid   in   1   pipeline writeback request
//  p0_rd      in   AW  pipeline destination register
//  p0_data    in   DW  pipeline writeback data
//  p1_valid   in   1   multi-cycle unit result valid
//  p1_ready   out  1   arbiter accepts p1 this cycle
//  p1_rd      in   AW  multi-cycle destination register
//  p1_data    in   DW  multi-cycle result data
//  chk_a1     in   AW  decode-stage read address 1
//  chk_a2     in   AW  decode-stage read address 2
//  hazard     out  1   chk_a1/chk_a2 matches a pending FIFO write
//  pipe_stall out  1   pipeline must hold its writeback stage this cycle
//  WE3        out  1   register file write enable
//  A3         out  AW  register file write address
//  WD3        out  DW  register file write data
// BEHAVIOUR
//  Reset: FIFO empty, starve_cnt=0. Outputs: p1_ready=1, hazard=0, pipe_stall=0, WE3=0.
//  Write-port outputs are combinational from current inputs and FIFO head (0-cycle latency).
//  A request is live only if its rd != 0.
//  - p0 rd==0: ignored.
//  - p1 rd==0: handshake completes, data dropped, nothing buffered.
//  Grant priority each cycle:
//   1. pipe_stall=1: FIFO head written; p0 ignored (pipeline re-presents it next cycle).
//   2. else live p0: p0 written.
//   3. else FIFO non-empty: FIFO head written and popped.
//   4. else live p1 with FIFO empty: p1 written directly (bypass), not buffered.
//   5. else WE3=0; A3 and WD3 are don't-care (drive 0).
//  p1 is accepted when p1_valid && p1_ready && it was not bypassed; it is then pushed.
//  p1_ready = (count < DEPTH). No push-on-pop when full: a same-cycle pop does not raise ready.
//  Push and pop in the same cycle: count unchanged; FIFO order preserved.
//  WAW squash: a granted p0 write to rd=X clears the valid bit of every FIFO entry with rd=X.
//   - p0 is younger and wins.
//   - Squashed entries are popped without a write (WE3=0 when the head is invalid).
//   - A squashed head pops in priority slot 3 or 1.
//  hazard = OR over valid entries of (rd==chk_a1 || rd==chk_a2), excluding address 0.
//   - Combinational; the incoming p1 is not included.
//  Starvation counter starve_cnt:
//   - Increments when the FIFO is non-empty and p0 wins.
//   - Clears on any pop or when the FIFO is empty.
//   - pipe_stall=1 for exactly one cycle when starve_cnt==STARVE_MAX-1 and p0 wins again;
//     the counter clears in that cycle.
//   - Correction: pipe_stall asserts in the cycle after that (registered flag).
//   - pipe_stall holds one cycle only; the counter restarts afterwards.
//  RST mid-operation: FIFO contents discarded, no write issued that cycle, all state to reset values.
// STRUCTURE
//  Package reg_arb_pkg:
//   - typedef wb_req_t {logic vld; logic [AW-1:0] rd; logic [DW-1:0] data;}
//   - constant REG_ZERO = '0.
//  Sub-module wb_fifo:
//   - DEPTH-entry circular FIFO of wb_req_t; rd/wr pointers with an extra wrap bit.
//   - Per-entry squash compare input; two-address hazard match output.
//  Top level: grant mux, bypass path, starvation counter, pipe_stall flag.
// TESTING
//  1. p0 only, rd=3/data=0xAA each cycle -> WE3=1, A3=3, WD3=0xAA same cycle; p1_ready=1.
//  2. p1 alone, rd=5/data=0x55, FIFO empty -> bypass write same cycle, count stays 0.
//  3. p0 and p1 both every cycle, DEPTH=4:
//     -> p1 fills 4 entries, p1_ready=0 on 5th;
//     -> pipe_stall pulses after STARVE_MAX=8 lost cycles and drains the head.
//  4. p1 rd=7 buffered, then p0 rd=7 data=0x11 -> entry squashed;
//     the later drain writes nothing; regfile x7=0x11.
//  5. FIFO holds rd=9, chk_a1=9 -> hazard=1; chk_a1=0, chk_a2=4 -> hazard=0; p1 rd=0 -> ready, no push.
//  6. RST asserted with 3 entries queued -> next cycle count=0, WE3=0, p1_ready=1, hazard=0.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
//   Shared types and constants for the register-file write-port arbiter.
//
//   REG_AW / REG_DW : storage widths of a buffered writeback request. The
//                     arbiter's ADDRESS_WIDTH / DATA_WIDTH parameters default
//                     to these and must stay equal to them.
//   REG_ZERO        : the hard-wired zero register. Writes to it are never
//                     live, and it never raises a hazard.
//   wb_req_t        : one writeback request (valid, destination, data).
//   addr_hit()      : a read-address match against a destination. A zero
//                     read address never matches.
// ---------------------------------------------------------------------------
package reg_arb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic [REG_DW-1:0] data;
  } wb_req_t;

  // Reading x0 can never conflict with a pending write, so a zero check
  // address is masked here rather than at every call site.
  function automatic logic addr_hit(input logic [REG_AW-1:0] entry_rd,
                                    input logic [REG_AW-1:0] chk);
    return (chk != REG_ZERO) && (entry_rd == chk);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   A DEPTH-entry circular FIFO that holds port-1 writeback requests that
//   lost arbitration. The read and write pointers carry an extra wrap bit,
//   so the full and empty states can be told apart.
//
//   Ports
//     clk, rst          : clock, synchronous active-high reset
//     push, push_req    : enqueue a request. Ignored when full.
//     pop               : dequeue the head. Ignored when empty.
//     squash_en/_rd     : clear the valid bit of every entry whose rd matches
//     chk_a1, chk_a2    : decode-stage read addresses for the hazard check
//     head              : the current head entry. head.vld=0 means the head
//                         was squashed, or the FIFO is empty.
//     empty, full       : occupancy flags
//     hazard            : some valid entry targets chk_a1 or chk_a2
// ---------------------------------------------------------------------------
module wb_fifo
  import reg_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_req_t           push_req,
  input  logic              pop,
  input  logic              squash_en,
  input  logic [REG_AW-1:0] squash_rd,
  input  logic [REG_AW-1:0] chk_a1,
  input  logic [REG_AW-1:0] chk_a2,
  output wb_req_t           head,
  output logic              empty,
  output logic              full,
  output logic              hazard
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]       wr_ptr_reg;
  logic [PW:0]       rd_ptr_reg;
  logic [PW-1:0]     wr_idx;
  logic [PW-1:0]     rd_idx;
  logic              push_fire;
  logic              pop_fire;
  logic [REG_AW-1:0] rd_mem   [DEPTH];
  logic [REG_DW-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  vld_vec;
  logic [DEPTH-1:0]  hit_vec;

  assign wr_idx = wr_ptr_reg[PW-1:0];
  assign rd_idx = rd_ptr_reg[PW-1:0];

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) && (wr_idx == rd_idx);

  assign push_fire = push && !full;
  assign pop_fire  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
      if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
    end
  end

  // The payload needs no reset. Occupancy and validity are tracked only by
  // the per-entry valid bits and the pointers.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      rd_mem[wr_idx]   <= push_req.rd;
      data_mem[wr_idx] <= push_req.data;
    end
  end

  // A valid bit is cleared when its entry is popped. So a set bit always
  // means "occupied and not squashed", and the hazard OR needs no separate
  // occupancy mask. A push never targets an occupied slot, so giving push
  // priority over squash cannot resurrect a squashed entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic vld_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_reg <= 1'b0;
        end else if (push_fire && (wr_idx == PW'(gi))) begin
          vld_reg <= push_req.vld;
        end else if (pop_fire && (rd_idx == PW'(gi))) begin
          vld_reg <= 1'b0;
        end else if (squash_en && vld_reg && (rd_mem[gi] == squash_rd)) begin
          vld_reg <= 1'b0;
        end
      end

      assign vld_vec[gi] = vld_reg;
      assign hit_vec[gi] = vld_reg &&
                           (addr_hit(rd_mem[gi], chk_a1) || addr_hit(rd_mem[gi], chk_a2));
    end
  endgenerate

  assign hazard = |hit_vec;

  always_comb begin
    head      = '0;
    head.vld  = vld_vec[rd_idx];
    head.rd   = rd_mem[rd_idx];
    head.data = data_mem[rd_idx];
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//   Shares the register file's single write port (WE3/A3/WD3) between two
//   writeback sources:
//     - port 0: the in-order pipeline writeback. It has top priority and no
//       back-pressure.
//     - port 1: a multi-cycle unit with a valid/ready handshake. Its results
//       wait in a DEPTH-entry FIFO when they cannot be written at once.
//   A decode-stage hazard flag reports reads of registers that still have a
//   write pending in the FIFO. If port 0 keeps winning while the FIFO holds
//   data, a one-cycle pipe_stall is raised so that the FIFO head can drain.
//
//   Ports
//     CLK, RST                   : clock, synchronous active-high reset
//     p0_valid/p0_rd/p0_data     : pipeline writeback request
//     p1_valid/p1_rd/p1_data     : multi-cycle unit result
//     p1_ready                   : port-1 handshake accept (FIFO not full)
//     chk_a1, chk_a2             : decode-stage read addresses
//     hazard                     : a read address matches a pending FIFO write
//     pipe_stall                 : the pipeline must hold its writeback stage
//     WE3/A3/WD3                 : register file write port (combinational)
// ---------------------------------------------------------------------------
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = REG_AW,
  parameter int DATA_WIDTH    = REG_DW,
  parameter int DEPTH         = 4,
  parameter int STARVE_MAX    = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     p0_valid,
  input  logic [ADDRESS_WIDTH-1:0] p0_rd,
  input  logic [DATA_WIDTH-1:0]    p0_data,
  input  logic                     p1_valid,
  output logic                     p1_ready,
  input  logic [ADDRESS_WIDTH-1:0] p1_rd,
  input  logic [DATA_WIDTH-1:0]    p1_data,
  input  logic [ADDRESS_WIDTH-1:0] chk_a1,
  input  logic [ADDRESS_WIDTH-1:0] chk_a2,
  output logic                     hazard,
  output logic                     pipe_stall,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] A3,
  output logic [DATA_WIDTH-1:0]    WD3
);

  localparam int CW = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;

  wb_req_t                  head;
  wb_req_t                  push_req;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_hazard;

  logic                     p0_live;
  logic                     p1_live;
  logic                     p0_win;
  logic                     bypass;
  logic                     p1_accept;
  logic                     lose;
  logic                     starve_hit;

  logic                     we_sel;
  logic [ADDRESS_WIDTH-1:0] a3_sel;
  logic [DATA_WIDTH-1:0]    wd3_sel;

  logic [CW-1:0]            starve_cnt_reg;
  logic [CW-1:0]            starve_cnt_next;
  logic                     stall_reg;

  // A write to the zero register is never a live request.
  assign p0_live = p0_valid && (p0_rd != REG_ZERO);
  assign p1_live = p1_valid && (p1_rd != REG_ZERO);

  assign pipe_stall = stall_reg;

  // Grant mux. It is purely combinational, so a winning request reaches the
  // register file in the same cycle that it is presented.
  always_comb begin
    we_sel   = 1'b0;
    a3_sel   = '0;
    wd3_sel  = '0;
    fifo_pop = 1'b0;
    p0_win   = 1'b0;
    bypass   = 1'b0;
    if (stall_reg) begin
      // Drain cycle. The pipeline holds p0 and presents it again next cycle.
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        if (head.vld) begin
          we_sel  = 1'b1;
          a3_sel  = head.rd;
          wd3_sel = head.data;
        end
      end
    end else if (p0_live) begin
      p0_win  = 1'b1;
      we_sel  = 1'b1;
      a3_sel  = p0_rd;
      wd3_sel = p0_data;
    end else if (!fifo_empty) begin
      // A squashed head still uses up this slot. It is popped, but no write
      // is issued for it.
      fifo_pop = 1'b1;
      if (head.vld) begin
        we_sel  = 1'b1;
        a3_sel  = head.rd;
        wd3_sel = head.data;
      end
    end else if (p1_live) begin
      bypass  = 1'b1;
      we_sel  = 1'b1;
      a3_sel  = p1_rd;
      wd3_sel = p1_data;
    end
  end

  // No write is allowed while reset is asserted. Otherwise a half-drained
  // FIFO could still put a stale head on the write port.
  assign WE3 = we_sel && !RST;
  assign A3  = RST ? '0 : a3_sel;
  assign WD3 = RST ? '0 : wd3_sel;

  // Ready depends only on the stored occupancy. A pop in the same cycle does
  // not free a slot for a push, which keeps ready off the grant path.
  assign p1_ready  = !fifo_full;
  assign p1_accept = p1_valid && p1_ready && !bypass;

  // A result for x0 completes its handshake but is never buffered.
  assign fifo_push = p1_accept && p1_live;

  always_comb begin
    push_req      = '0;
    push_req.vld  = 1'b1;
    push_req.rd   = p1_rd;
    push_req.data = p1_data;
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (fifo_push),
    .push_req  (push_req),
    .pop       (fifo_pop),
    .squash_en (p0_win),
    .squash_rd (p0_rd),
    .chk_a1    (chk_a1),
    .chk_a2    (chk_a2),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .hazard    (fifo_hazard)
  );

  // The incoming p1 request is deliberately left out of the hazard flag.
  assign hazard = fifo_hazard;

  // Starvation tracking. A "lost" cycle is one in which p0 takes the port
  // while the FIFO has something waiting. The STARVE_MAX-th consecutive lost
  // cycle arms the stall flag for the following cycle. Any pop, or an empty
  // FIFO, restarts the count.
  assign lose       = p0_win && !fifo_empty;
  assign starve_hit = lose && (starve_cnt_reg == CW'(STARVE_MAX - 1));

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (fifo_pop || fifo_empty || starve_hit) begin
      starve_cnt_next = '0;
    end else if (lose) begin
      starve_cnt_next = starve_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt_reg <= '0;
      stall_reg      <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      stall_reg      <= starve_hit;
    end
  end

endmodule
